// File: rtl/wb_dbg_pkg.sv
// Shared definitions for the UART-driven Wishbone debug master: FSM encoding,
// command bytes and response status bytes.
package wb_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BUS   = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

endpackage

// File: rtl/wb_dbg_resp_ser.sv
// Response serialiser: loads a status byte plus an optional 32-bit word and
// shifts it out MSB first over a valid/ready handshake.
module wb_dbg_resp_ser
    import wb_dbg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        ok_i,
    input  logic        has_word_i,
    input  logic [31:0] word_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [39:0] sh_q;
    logic [2:0]  left_q;   // bytes still to send after the current one
    logic        vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            left_q <= '0;
            vld_q  <= 1'b0;
        end else if (load_i) begin
            sh_q   <= {(ok_i ? RSP_OK : RSP_ERR), word_i};
            left_q <= has_word_i ? 3'd4 : 3'd0;
            vld_q  <= 1'b1;
        end else if (vld_q && tx_ready_i) begin
            if (left_q == 3'd0) begin
                vld_q <= 1'b0;
            end else begin
                sh_q   <= {sh_q[31:0], 8'h00};
                left_q <= left_q - 3'd1;
            end
        end
    end

    assign tx_data_o  = sh_q[39:32];
    assign tx_valid_o = vld_q;
    assign done_o     = vld_q && tx_ready_i && (left_q == 3'd0);

endmodule

// File: rtl/wb_uart_dbg_master.sv
// Byte-stream command decoder driving a single-beat Wishbone classic cycle.
// Optional bus timeout is enabled by defining WB_DBG_TIMEOUT_EN.
module wb_uart_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] CMD_WRITE      = wb_dbg_pkg::CMD_WRITE,
    parameter logic [7:0] CMD_READ       = wb_dbg_pkg::CMD_READ
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        overrun_o
);

    state_e      state_q;
    logic        we_q;
    logic [1:0]  cnt_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        cyc_q;
    logic        overrun_q;
    logic        tmo_hit;
    logic        bus_end;
    logic        ser_done;

`ifdef WB_DBG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the bus waits forever; this keeps the parameter referenced.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign bus_end = (state_q == S_BUS) && (wb_ack_i || wb_err_i || tmo_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            cyc_q     <= 1'b0;
            overrun_q <= 1'b0;
`ifdef WB_DBG_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            if (rx_valid_i && (state_q == S_BUS || state_q == S_RESP))
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: if (rx_valid_i && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) begin
                    we_q    <= (rx_data_i == CMD_WRITE);
                    cnt_q   <= '0;
                    state_q <= S_ADDR;
                end
                S_ADDR: if (rx_valid_i) begin
                    adr_q <= {adr_q[23:0], rx_data_i};
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q <= S_BUS;
                            cyc_q   <= 1'b1;
`ifdef WB_DBG_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end
                    end
                end
                S_WDATA: if (rx_valid_i) begin
                    dat_q <= {dat_q[23:0], rx_data_i};
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= S_BUS;
                        cyc_q   <= 1'b1;
`ifdef WB_DBG_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                S_BUS: if (bus_end) begin
                    cyc_q   <= 1'b0;
                    state_q <= S_RESP;
                end else begin
`ifdef WB_DBG_TIMEOUT_EN
                    tmo_q <= tmo_q + 1'b1;
`endif
                end
                S_RESP: if (ser_done) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read data is captured by the serialiser on the ack edge; err takes priority.
    wb_dbg_resp_ser u_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (bus_end),
        .ok_i       (wb_ack_i && !wb_err_i),
        .has_word_i (wb_ack_i && !wb_err_i && !we_q),
        .word_i     (wb_dat_i),
        .tx_ready_i (tx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .done_o     (ser_done)
    );

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = cyc_q & we_q;
    assign wb_sel_o  = {4{cyc_q}};
    assign busy_o    = (state_q != S_IDLE);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_wb_uart_dbg_master.sv
// Directed bench for wb_uart_dbg_master with a response-byte scoreboard.
// Timeout checks follow WB_DBG_TIMEOUT_EN (TIMEOUT_CYCLES = 16 here).
module tb_wb_uart_dbg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic        wb_ack = 1'b0, wb_err = 1'b0;
    logic        busy, overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // slave model control: mode 0 ack, 1 err, 2 ack+err, 3 never respond
    int          slv_mode = 0;
    int          slv_wait = 0;
    logic [31:0] slv_rdata = '0;
    int          bus_cnt = 0;
    int          ncyc = 0;
    int          unstable = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic        rdy_toggle = 1'b0;

    wb_uart_dbg_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_w), .wb_dat_i(wb_dat_r),
        .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err),
        .busy_o(busy), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Wishbone slave: answers after slv_wait extra cycles, records the request.
    initial begin
        wb_dat_r = '0;
        forever begin
            @(posedge clk); #1;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_cyc && wb_stb) begin
                if (bus_cnt == 0) begin
                    cap_adr = wb_adr; cap_dat = wb_dat_w; cap_we = wb_we; cap_sel = wb_sel;
                    ncyc++;
                end else if (wb_adr !== cap_adr || wb_dat_w !== cap_dat || wb_we !== cap_we) begin
                    unstable++;
                end
                if (bus_cnt == slv_wait && slv_mode != 3) begin
                    wb_ack   = (slv_mode == 0 || slv_mode == 2);
                    wb_err   = (slv_mode == 1 || slv_mode == 2);
                    wb_dat_r = slv_rdata;
                end
                bus_cnt++;
            end else begin
                bus_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_toggle) tx_ready = ~tx_ready;
            else            tx_ready = 1'b1;
        end
    end

    // Handshake as seen at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc1();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc1();
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        send_byte(c);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        if (c == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    endtask

    // Waits (bounded) for every expected byte, compares in order, then checks no extras.
    task automatic check_resp(input string tag);
        int n;
        int t;
        n = exp_q.size();
        t = 0;
        while (got_q.size() < n && t < 300) begin cyc1(); t++; end
        chk({tag, "_count"}, 40'(got_q.size()), 40'(n));
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            chk({tag, "_byte"}, 40'(g), 40'(e));
        end
        repeat (4) cyc1();
        chk({tag, "_extra"}, 40'(got_q.size()), 40'd0);
        chk({tag, "_idle"}, 40'(busy), 40'd0);
        got_q.delete();
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) cyc1();
        chk("rst_wb", 40'({wb_cyc, wb_stb, wb_we, wb_sel}), 40'd0);
        chk("rst_tx", 40'({tx_valid, tx_data}), 40'd0);
        chk("rst_flags", 40'({busy, overrun}), 40'd0);
        chk("rst_adr", 40'(wb_adr), 40'd0);
        rst = 1'b0;
        cyc1();

        // write with two wait states
        slv_mode = 0; slv_wait = 2; ncyc = 0;
        exp_q.push_back(8'h4B);
        send_cmd(8'h57, 32'h1000_0004, 32'hDEAD_BEEF);
        check_resp("wr");
        chk("wr_req", {cap_we, cap_sel, cap_adr}, {1'b1, 4'hF, 32'h1000_0004});
        chk("wr_dat", 40'(cap_dat), 40'hDEAD_BEEF);
        chk("wr_ncyc", 40'(ncyc), 40'd1);

        // minimum latency write
        slv_wait = 0;
        exp_q.push_back(8'h4B);
        send_cmd(8'h57, 32'h0000_0010, 32'h0102_0304);
        chk("lat_cyc", 40'({wb_cyc, wb_stb, tx_valid}), 40'b110);
        cyc1();
        chk("lat_k", 40'({wb_cyc, tx_valid, tx_data}), {30'd0, 2'b01, 8'h4B});
        check_resp("lat");

        // read with ready toggling
        slv_wait = 1; slv_rdata = 32'h0000_00A5; rdy_toggle = 1'b1; ncyc = 0;
        exp_q.push_back(8'h4B); push_word(32'h0000_00A5);
        send_cmd(8'h52, 32'h1000_0000, 32'h0);
        check_resp("rd");
        rdy_toggle = 1'b0;
        chk("rd_req", {cap_we, cap_sel, cap_adr}, {1'b0, 4'hF, 32'h1000_0000});

        // error read, then ack+err together
        slv_mode = 1; slv_wait = 0;
        exp_q.push_back(8'h45);
        send_cmd(8'h52, 32'h2000_0000, 32'h0);
        check_resp("err");
        slv_mode = 2; slv_rdata = 32'h1111_2222;
        exp_q.push_back(8'h45);
        send_cmd(8'h52, 32'h2000_0000, 32'h0);
        check_resp("both");

        // junk in IDLE, then read with a byte injected during BUS
        slv_mode = 0; slv_wait = 4; slv_rdata = 32'h1234_5678;
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("junk_idle", 40'({busy, overrun}), 40'd0);
        exp_q.push_back(8'h4B); push_word(32'h1234_5678);
        send_cmd(8'h52, 32'h3000_0008, 32'h0);
        send_byte(8'h52);
        chk("ovr_set", 40'({overrun, wb_cyc}), 40'b11);
        check_resp("ovr");
        chk("ovr_sticky", 40'(overrun), 40'd1);

        // reset in the middle of a bus cycle
        slv_mode = 3;
        send_cmd(8'h57, 32'h4000_0000, 32'h5555_AAAA);
        repeat (3) cyc1();
        chk("mid_cyc", 40'(wb_cyc), 40'd1);
        rst = 1'b1;
        cyc1();
        chk("mid_rst", 40'({wb_cyc, wb_stb, busy, tx_valid, overrun}), 40'd0);
        rst = 1'b0;
        cyc1();
        got_q.delete();
        slv_mode = 0; slv_wait = 0; ncyc = 0;
        exp_q.push_back(8'h4B);
        send_cmd(8'h57, 32'h4000_0004, 32'hCAFE_F00D);
        check_resp("post");
        chk("post_req", {cap_we, cap_sel, cap_adr}, {1'b1, 4'hF, 32'h4000_0004});

        // slave that never answers
        slv_mode = 3;
`ifdef WB_DBG_TIMEOUT_EN
        exp_q.push_back(8'h45);
        send_cmd(8'h52, 32'h5000_0000, 32'h0);
        n = 0;
        while (wb_cyc && n < 200) begin n++; cyc1(); end
        chk("tmo_len", 40'(n), 40'd16);
        check_resp("tmo");
`else
        send_cmd(8'h52, 32'h5000_0000, 32'h0);
        n = 0;
        for (int i = 0; i < 100; i++) begin if (wb_cyc) n++; cyc1(); end
        chk("notmo_cyc", 40'({n, wb_cyc, busy}), {n, 2'b11});
        chk("notmo_n", 40'(n), 40'd100);
        chk("notmo_tx", 40'(got_q.size()), 40'd0);
        rst = 1'b1; cyc1(); rst = 1'b0; cyc1();
`endif
        chk("stable", 40'(unstable), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_uart_dbg_master.md
Name: wb_uart_dbg_master

Overview:
- Wishbone classic initiator driven by a byte-stream command protocol; the debug/host end of the Wishbone bus whose slaves include the UART peripheral.
- Bytes arrive from a UART receiver. The block assembles read/write commands, runs one single-beat Wishbone cycle, and returns status/data bytes to a UART transmitter.
- Lets an external host peek/poke any Wishbone address without the RV32I core.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles of a Wishbone cycle without ack/err before abort (used only with WB_DBG_TIMEOUT_EN).
- CMD_WRITE, 8'h57: command byte 'W'.
- CMD_READ, 8'h52: command byte 'R'.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  response byte valid; held until accepted
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o&&tx_ready_i
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_sel_o  out  4  byte selects (always 4'hF while cycle active)
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave ack
- wb_err_i  in  1  slave error
- busy_o  out  1  high in any state other than IDLE
- overrun_o  out  1  sticky: a byte arrived while not in IDLE/ADDR/WDATA; cleared only by reset

Behaviour:
- Reset (rst_i high at clk_i edge): state IDLE; all outputs 0; counters cleared. Mid-operation reset abandons the bus cycle (cyc/stb low next cycle) and drops any pending response.
- Protocol (all multi-byte fields MSB first):
  - Write: 'W' A3 A2 A1 A0 D3 D2 D1 D0 -> response 'K' (8'h4B) on ack, 'E' (8'h45) on err/timeout.
  - Read: 'R' A3..A0 -> 'K' D3 D2 D1 D0 on ack, single 'E' on err/timeout.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
  - IDLE: on rx_valid_i, CMD_WRITE/CMD_READ latches we and goes to ADDR with byte count 0. Any other byte is silently discarded; stay IDLE.
  - ADDR: each rx_valid_i shifts the byte into the address register (addr <= {addr[23:0], byte}). After 4th byte: write -> WDATA; read -> BUS.
  - WDATA: same shifting into the data register; after 4th byte -> BUS.
  - BUS: wb_cyc_o=wb_stb_o=1 and wb_sel_o=4'hF from the first BUS cycle; wb_adr_o/wb_dat_o/wb_we_o stable throughout.
    - On the first cycle with wb_ack_i or wb_err_i high, that edge drops cyc/stb (registered low next cycle), latches wb_dat_i on a read ack, sets status, and goes to RESP.
    - Ack and err both high: err wins.
  - RESP: tx_valid_o=1 with current byte. On tx_valid_o&&tx_ready_i advance; byte sequence per protocol. After last byte accepted -> IDLE (busy_o low the following cycle).
- Minimum latency, write, slave acks in the first BUS cycle: cyc asserted the cycle after 9th byte strobe; 'K' valid 2 cycles after that strobe.
- rx_valid_i in BUS/RESP: byte dropped, overrun_o set. Not queued.
- Outside BUS, wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o are 0. wb_adr_o/wb_dat_o are don't-care but held at the register value.
- No inter-byte timeout: a partial command waits indefinitely.

Optional Feature:
- Macro WB_DBG_TIMEOUT_EN.
- Defined: a cycle counter runs in BUS. Reaching TIMEOUT_CYCLES with no ack/err aborts the cycle (cyc/stb low next cycle) and responds 'E'. Counter clears on BUS entry.
- Undefined: no counter; BUS waits forever for ack/err.

Decomposition:
- Shared package wb_dbg_pkg: state enum encoding, CMD_WRITE, CMD_READ, RSP_OK (8'h4B), RSP_ERR (8'h45).
- One natural sub-module, wb_dbg_resp_ser: loads status plus optional 32-bit word and serialises it over the tx valid/ready handshake. Top keeps the command FSM and Wishbone driver.

Test Plan:
- Write: bytes 57 10 00 00 04 DE AD BE EF, slave acks after 2 wait states -> one cycle adr=32'h1000_0004, dat=32'hDEADBEEF, we=1, sel=F; response single 4B.
- Read: bytes 52 10 00 00 00, slave returns 32'h0000_00A5 with ack -> we=0, response 4B 00 00 00 A5. tx_ready_i toggled 1/0 each cycle: no byte lost or duplicated.
- Error: read 52 20 00 00 00 with wb_err_i pulsed -> response single 45. Ack and err same cycle -> 45.
- Junk and overrun: bytes 00 FF then valid read -> junk ignored, read completes. Byte sent during BUS -> overrun_o=1, dropped, response unchanged.
- Reset mid-BUS: assert rst_i while cyc high -> cyc/stb/busy_o/tx_valid_o 0 next cycle; fresh write afterwards succeeds.
- With WB_DBG_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> cyc drops after 16 BUS cycles, response 45. Without macro, cyc stays high after 100 cycles.
